// File: rtl/instr_fetch_unit_pkg.sv
// Shared RISC-V fetch definitions: widths, reset address, fetch FSM states.
package riscv_pkg;

  localparam int unsigned       XLEN             = 32;
  localparam logic [XLEN-1:0]   DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0]   NOP_INSTR        = 32'h0000_0013;

  typedef enum logic {
    FETCH,
    FLUSH
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface instr_fetch_unit_if
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [XLEN-1:0]       imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Small circular buffer holding {pc, instr} pairs; clear empties it in one cycle.
module fetch_fifo #(
  parameter int unsigned       DEPTH      = 2,
  parameter int unsigned       WIDTH      = 64,
  parameter logic [WIDTH-1:0]  RESET_WORD = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             rd_ptr;
  ptr_t             wr_ptr;

  function automatic ptr_t bump(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_WORD;
      end
    end else if (clear) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      count <= count + cnt_t'(push) - cnt_t'(pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == cnt_t'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests, buffers words, handles redirects.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC[ADDR_WIDTH-1:0],
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  instr_fetch_unit_if.master    imem,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [XLEN-1:0]       Instr,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [ADDR_WIDTH-1:0] PCPlus4,
  input  logic                  PCSrc,
  input  logic [ADDR_WIDTH-1:0] PCTarget
);

  localparam int unsigned           CW         = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned           FW         = ADDR_WIDTH + XLEN;
  localparam logic [CW:0]           DEPTH_C    = FIFO_DEPTH[CW:0];
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = 4;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));

  typedef logic [CW-1:0] cnt_t;

  fetch_state_t          state, state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  cnt_t                  outstanding, discard, fifo_count;
  cnt_t                  out_calc, out_nxt, disc_nxt, count_nxt;
  logic [CW:0]           occ_nxt;
  logic                  req_valid_q, req_nxt;
  logic                  req_fire, rsp_fetch, rsp_flush, push, pop, redirect;
  logic                  fifo_full, fifo_empty;
  logic [FW-1:0]         fifo_head;

  // Outstanding requests are always contiguous from the last redirect, so the
  // oldest one's address is recovered from fetch_pc rather than stored per entry.
  assign rsp_pc = fetch_pc - ({{(ADDR_WIDTH-CW){1'b0}}, outstanding} << 2);

  always_comb begin
    req_fire  = req_valid_q & imem.imem_req_ready;
    rsp_fetch = imem.imem_rsp_valid & (state == FETCH);
    rsp_flush = imem.imem_rsp_valid & (state == FLUSH);
    pop       = instr_valid & instr_ready;
    redirect  = PCSrc & pop;
    push      = rsp_fetch & ~redirect;

    out_calc  = outstanding + cnt_t'(req_fire) - cnt_t'(rsp_fetch);
    out_nxt   = out_calc;
    disc_nxt  = discard - cnt_t'(rsp_flush);
    count_nxt = fifo_count + cnt_t'(push) - cnt_t'(pop);
    state_nxt = state;

    if (redirect) begin
      out_nxt   = '0;
      disc_nxt  = out_calc;
      count_nxt = '0;
      state_nxt = (out_calc != '0) ? FLUSH : FETCH;
    end else if (state == FLUSH && disc_nxt == '0) begin
      state_nxt = FETCH;
    end

    occ_nxt = {1'b0, out_nxt} + {1'b0, count_nxt};
    req_nxt = (state_nxt == FETCH) && (occ_nxt < DEPTH_C);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      req_valid_q <= 1'b0;
    end else begin
      assert (!(push && fifo_full && !pop));
      state       <= state_nxt;
      outstanding <= out_nxt;
      discard     <= disc_nxt;
      req_valid_q <= req_nxt;
      if (redirect) begin
        fetch_pc <= PCTarget & ALIGN_MASK;
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + WORD_STEP;
      end
    end
  end

  fetch_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .WIDTH      (FW),
    .RESET_WORD ({RESET_PC, {XLEN{1'b0}}})
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata ({rsp_pc, imem.imem_rsp_data}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_req_addr  = fetch_pc;
  assign instr_valid         = ~fifo_empty;
  assign Instr               = fifo_head[XLEN-1:0];
  assign PC                  = fifo_head[FW-1:XLEN];
  assign PCPlus4             = PC + WORD_STEP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit against a queue-based fetch model.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        instr_valid, instr_ready, PCSrc;
  logic [31:0] Instr, PC, PCPlus4, PCTarget;

  always #5 CLK = ~CLK;

  instr_fetch_unit_if #(.ADDR_WIDTH(32)) imem ();

  instr_fetch_unit #(
    .ADDR_WIDTH (32),
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .imem        (imem),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .Instr       (Instr),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .PCSrc       (PCSrc),
    .PCTarget    (PCTarget)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // reference model: expected next fetch address, live requests, buffered words
  logic [31:0] m_fetch_pc;
  logic [31:0] m_pend[$];
  logic [31:0] m_buf[$];
  int unsigned m_discard;
  bit          m_after_rst;
  mreq_t       memq[$];
  logic [31:0] consumed[$];

  int unsigned cyc        = 0;
  int unsigned lat        = 1;
  bit          lat_rand   = 1'b0;
  int unsigned ready_pct  = 100;
  int unsigned iready_pct = 100;

  logic        s_rv, s_iv;
  logic [31:0] s_ra, s_pc, s_pc4, s_instr;
  logic [31:0] head;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample_and_check();
    logic exp_rv;
    s_rv    = imem.imem_req_valid;
    s_ra    = imem.imem_req_addr;
    s_iv    = instr_valid;
    s_pc    = PC;
    s_pc4   = PCPlus4;
    s_instr = Instr;
    exp_rv  = !m_after_rst && (m_discard == 0) && ((m_pend.size() + m_buf.size()) < DEPTH);
    chk("req_valid", 32'(s_rv), 32'(exp_rv));
    if (s_rv) chk("req_addr", s_ra, m_fetch_pc);
    chk("instr_valid", 32'(s_iv), 32'(m_buf.size() != 0));
    if (m_buf.size() != 0) begin
      chk("head_pc", s_pc, m_buf[0]);
      chk("head_instr", s_instr, mem_word(m_buf[0]));
      chk("head_pc_plus4", s_pc4, m_buf[0] + 32'd4);
    end
  endtask

  // One clock: drive inputs now (at negedge), update model at posedge, check at next negedge.
  task automatic cycle(input bit src, input logic [31:0] tgt);
    bit          fire, rsp, pop, redir;
    logic [31:0] a;
    imem.imem_req_ready = ($urandom_range(99) < ready_pct);
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data  = mem_word(memq[0].addr);
    end else begin
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = $urandom;
    end
    instr_ready = ($urandom_range(99) < iready_pct);
    PCSrc       = src;
    PCTarget    = tgt;
    @(posedge CLK);
    if (!RST) begin
      m_fetch_pc  = RPC;
      m_pend.delete();
      m_buf.delete();
      m_discard   = 0;
      memq.delete();
      m_after_rst = 1'b1;
    end else begin
      fire  = s_rv && imem.imem_req_ready;
      rsp   = imem.imem_rsp_valid;
      pop   = s_iv && instr_ready;
      redir = pop && PCSrc;
      if (rsp && memq.size() != 0) void'(memq.pop_front());
      if (pop) begin
        consumed.push_back(s_pc);
        if (m_buf.size() != 0) void'(m_buf.pop_front());
      end
      if (rsp) begin
        if (m_discard > 0) m_discard--;
        else if (m_pend.size() != 0) begin
          a = m_pend.pop_front();
          if (!redir) m_buf.push_back(a);
        end
      end
      if (fire) begin
        memq.push_back('{addr: s_ra, due: cyc + (lat_rand ? $urandom_range(4, 1) : lat)});
        m_pend.push_back(m_fetch_pc);
      end
      if (redir) begin
        m_discard  = m_pend.size();
        m_pend.delete();
        m_buf.delete();
        m_fetch_pc = tgt & 32'hFFFF_FFFC;
      end else if (fire) begin
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      m_after_rst = 1'b0;
    end
    cyc++;
    @(negedge CLK);
    sample_and_check();
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !s_iv; i++) cycle(1'b0, $urandom);
    chk(tag, 32'(s_iv), 32'd1);
  endtask

  initial begin
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    PCTarget    = '0;
    m_fetch_pc  = RPC;
    m_discard   = 0;
    m_after_rst = 1'b1;
    @(negedge CLK);
    s_rv = 1'b0;
    s_iv = 1'b0;

    // 1: reset values, then streaming from RESET_PC with single-cycle memory
    RST = 1'b0;
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    chk("rst_instr", s_instr, 32'h0);
    chk("rst_pc", s_pc, RPC);
    chk("rst_pc_plus4", s_pc4, RPC + 32'd4);
    RST = 1'b1;
    consumed.delete();
    for (int i = 0; i < 30; i++) cycle(1'b0, $urandom);
    chk("t1_count", 32'(consumed.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < consumed.size(); i++) chk("t1_seq", consumed[i], 32'(i * 4));

    // 2: latency 3 with execute stalled, then drain in order
    RST = 1'b0;
    cycle(1'b0, '0);
    RST = 1'b1;
    lat = 3;
    iready_pct = 0;
    consumed.delete();
    for (int i = 0; i < 15; i++) cycle(1'b0, $urandom);
    chk("t2_hold_valid", 32'(s_iv), 32'd1);
    chk("t2_hold_pc", s_pc, RPC);
    iready_pct = 100;
    for (int i = 0; i < 25; i++) cycle(1'b0, $urandom);
    chk("t2_drain_count", 32'(consumed.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < consumed.size(); i++) chk("t2_drain_seq", consumed[i], 32'(i * 4));

    // 3: redirect to 0x100 with responses still in flight
    lat = 4;
    wait_valid("t3_wait_head");
    cycle(1'b1, 32'h0000_0100);
    wait_valid("t3_wait_target");
    chk("t3_target_pc", s_pc, 32'h0000_0100);

    // 4: PCSrc without instr_ready is ignored; misaligned target is aligned
    lat = 2;
    iready_pct = 0;
    wait_valid("t4_wait_head");
    head = s_pc;
    cycle(1'b1, 32'h0000_0400);
    iready_pct = 100;
    consumed.delete();
    cycle(1'b0, $urandom);
    chk("t4_ignored_pop", consumed.size() != 0 ? consumed[0] : 32'hDEAD_BEEF, head);
    chk("t4_after_ignored", s_pc, head + 32'd4);
    wait_valid("t4_wait_redir");
    cycle(1'b1, 32'h0000_0203);
    for (int i = 0; i < 20 && !s_rv; i++) cycle(1'b0, $urandom);
    chk("t4_aligned_req", s_ra, 32'h0000_0200);

    // 5: fetch address wraps past 0xFFFFFFFC
    wait_valid("t5_wait_head");
    cycle(1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 40 && !(s_iv && s_pc == 32'hFFFF_FFFC); i++) cycle(1'b0, $urandom);
    chk("t5_last_pc", s_pc, 32'hFFFF_FFFC);
    chk("t5_last_pc_plus4", s_pc4, 32'h0000_0000);
    for (int i = 0; i < 40 && !(s_iv && s_pc != 32'hFFFF_FFFC); i++) cycle(1'b0, $urandom);
    chk("t5_wrap_pc", s_pc, 32'h0000_0000);

    // 6: reset with one word buffered and one outstanding
    lat = 3;
    iready_pct = 0;
    for (int i = 0; i < 30 && !(m_pend.size() == 1 && m_buf.size() == 1); i++) cycle(1'b0, $urandom);
    chk("t6_setup", 32'(m_pend.size() == 1 && m_buf.size() == 1), 32'd1);
    RST = 1'b0;
    cycle(1'b0, $urandom);
    chk("t6_rst_instr", s_instr, 32'h0);
    chk("t6_rst_pc", s_pc, RPC);
    chk("t6_rst_pc_plus4", s_pc4, RPC + 32'd4);
    RST = 1'b1;
    iready_pct = 100;
    for (int i = 0; i < 10 && !s_rv; i++) cycle(1'b0, $urandom);
    chk("t6_restart_addr", s_ra, RPC);

    // randomized traffic: backpressure on both sides, variable latency, redirects
    lat_rand   = 1'b1;
    ready_pct  = 70;
    iready_pct = 60;
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(9) == 0), $urandom);
    end
    lat_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
